// File: rtl/fb_pkg.sv
// fb_pkg: framebuffer geometry constants and shared types for the write arbiter
package fb_pkg;
  localparam int RES_X = 320;
  localparam int RES_Y = 240;
  localparam int MEM_WIDTH = 8;
  localparam int MEM_DEPTH = RES_X * RES_Y;
  localparam int ADDR_WIDTH = $clog2(MEM_DEPTH);
  localparam int X_W = $clog2(RES_X);
  localparam int Y_W = $clog2(RES_Y);
  typedef enum logic {IDLE, CLEAR} state_t;
  typedef logic [MEM_WIDTH-1:0] pixel_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant; priority moves past the last granted requester on accept
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               accept,
  output logic [NUM_REQ-1:0] grant
);
  localparam int PW = $clog2(NUM_REQ);
  logic [PW-1:0] ptr, nxt;
  // scan from farthest to nearest so the requester closest to ptr wins
  always_comb begin
    grant = '0;
    nxt = ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % NUM_REQ]) begin
        grant = '0;
        grant[(int'(ptr) + k) % NUM_REQ] = 1'b1;
        nxt = PW'((int'(ptr) + k + 1) % NUM_REQ);
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr <= '0;
    else if (accept) ptr <= nxt;
endmodule

// File: rtl/fb_write_arbiter.sv
// fb_write_arbiter: shares the framebuffer write port between pixel writers and a full-screen clear
module fb_write_arbiter
  import fb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*X_W-1:0]       req_x,
  input  logic [NUM_REQ*Y_W-1:0]       req_y,
  input  logic [NUM_REQ*MEM_WIDTH-1:0] req_data,
  input  logic                         clear_start,
  input  logic [MEM_WIDTH-1:0]         clear_color,
  output logic                         clear_busy,
  output logic                         clear_done,
  output logic                         drop_err,
  output logic [ADDR_WIDTH-1:0]        mem_addr,
  output logic [MEM_WIDTH-1:0]         din,
  output logic                         wen
);
  state_t state;
  logic [NUM_REQ-1:0] grant;
  logic [X_W-1:0] sel_x;
  logic [Y_W-1:0] sel_y;
  pixel_t sel_d;
  logic acc, in_range;
  logic [ADDR_WIDTH-1:0] lin;
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk(clk), .rst_n(rst_n), .req(req_valid), .accept(acc), .grant(grant)
  );
  assign req_ready = (rst_n && state == IDLE && !clear_start) ? grant : '0;
  assign acc = |(req_valid & req_ready);
  assign clear_busy = (state == CLEAR);
  always_comb begin
    sel_x = '0;
    sel_y = '0;
    sel_d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_x = sel_x | req_x[i*X_W +: X_W];
        sel_y = sel_y | req_y[i*Y_W +: Y_W];
        sel_d = sel_d | req_data[i*MEM_WIDTH +: MEM_WIDTH];
      end
    end
  end
  assign in_range = (int'(sel_x) < RES_X) && (int'(sel_y) < RES_Y);
  assign lin = ADDR_WIDTH'(sel_y) * ADDR_WIDTH'(RES_X) + ADDR_WIDTH'(sel_x);
  // during a clear, mem_addr doubles as the clear counter and din holds the captured color
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      mem_addr <= '0;
      din <= '0;
      wen <= 1'b0;
      clear_done <= 1'b0;
      drop_err <= 1'b0;
    end else begin
      wen <= 1'b0;
      clear_done <= 1'b0;
      drop_err <= 1'b0;
      if (state == CLEAR) begin
        if (mem_addr == ADDR_WIDTH'(MEM_DEPTH - 1)) begin
          state <= IDLE;
          clear_done <= 1'b1;
        end else begin
          wen <= 1'b1;
          mem_addr <= mem_addr + 1'b1;
        end
      end else if (clear_start) begin
        state <= CLEAR;
        wen <= 1'b1;
        mem_addr <= '0;
        din <= clear_color;
      end else if (acc) begin
        if (in_range) begin
          wen <= 1'b1;
          mem_addr <= lin;
          din <= sel_d;
        end else begin
          drop_err <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_fb_write_arbiter.sv
// tb_fb_write_arbiter: vector table, round-robin/random reference model and clear/abort sequences
module tb_fb_write_arbiter;
  localparam int N = 2;
  localparam int DEPTH = 320 * 240;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] req_valid = '0;
  logic [N-1:0] req_ready;
  logic [N*9-1:0] req_x = '0;
  logic [N*8-1:0] req_y = '0;
  logic [N*8-1:0] req_data = '0;
  logic clear_start = 1'b0;
  logic [7:0] clear_color = '0;
  logic clear_busy, clear_done, drop_err, wen;
  logic [16:0] mem_addr;
  logic [7:0] din;
  int pass_cnt = 0;
  int total_cnt = 0;
  int last_g = N - 1;
  fb_write_arbiter #(.NUM_REQ(N)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_data(req_data),
    .clear_start(clear_start), .clear_color(clear_color),
    .clear_busy(clear_busy), .clear_done(clear_done), .drop_err(drop_err),
    .mem_addr(mem_addr), .din(din), .wen(wen)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask
  task automatic set_req(input int v, input int x0, input int y0, input int d0,
                         input int x1, input int y1, input int d1);
    req_valid = N'(v);
    req_x = {9'(x1), 9'(x0)};
    req_y = {8'(y1), 8'(y0)};
    req_data = {8'(d1), 8'(d0)};
  endtask
  typedef struct {
    int v, x0, y0, d0, x1, y1, d1;
    int rdy, w, a, d, drop;
  } vec_t;
  vec_t tv[8];
  int ex_w, ex_a, ex_d, ex_drop, g, bad, xs[N], ys[N], ds[N];
  initial begin
    tv[0] = '{1, 10, 10, 12, 0, 0, 0, 1, 1, 3210, 12, 0};
    tv[1] = '{3, 1, 0, 17, 2, 0, 34, 2, 1, 2, 34, 0};
    tv[2] = '{3, 1, 0, 17, 2, 0, 34, 1, 1, 1, 17, 0};
    tv[3] = '{1, 320, 0, 99, 0, 0, 0, 1, 0, 1, 17, 1};
    tv[4] = '{2, 0, 0, 0, 0, 240, 98, 2, 0, 1, 17, 1};
    tv[5] = '{1, 319, 239, 255, 0, 0, 0, 1, 1, 76799, 255, 0};
    tv[6] = '{0, 5, 5, 5, 6, 6, 6, 0, 0, 76799, 255, 0};
    tv[7] = '{2, 0, 0, 0, 0, 1, 90, 2, 1, 320, 90, 0};
    #3;
    chk("rst_wen", int'(wen), 0);
    chk("rst_addr", int'(mem_addr), 0);
    chk("rst_din", int'(din), 0);
    chk("rst_busy", int'(clear_busy), 0);
    chk("rst_done", int'(clear_done), 0);
    chk("rst_drop", int'(drop_err), 0);
    chk("rst_ready", int'(req_ready), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    foreach (tv[i]) begin
      set_req(tv[i].v, tv[i].x0, tv[i].y0, tv[i].d0, tv[i].x1, tv[i].y1, tv[i].d1);
      @(negedge clk);
      chk($sformatf("vec%0d_ready", i), int'(req_ready), tv[i].rdy);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_wen", i), int'(wen), tv[i].w);
      chk($sformatf("vec%0d_addr", i), int'(mem_addr), tv[i].a);
      chk($sformatf("vec%0d_din", i), int'(din), tv[i].d);
      chk($sformatf("vec%0d_drop", i), int'(drop_err), tv[i].drop);
    end
    for (int i = 0; i < 6; i++) begin
      set_req(3, i, 0, i, 100 + i, 0, 100 + i);
      @(negedge clk);
      chk($sformatf("cont%0d_ready", i), int'(req_ready), (i % 2) ? 2 : 1);
      @(posedge clk); #1;
      chk($sformatf("cont%0d_wen", i), int'(wen), 1);
      chk($sformatf("cont%0d_din", i), int'(din), (i % 2) ? 100 + i : i);
    end
    last_g = 1;
    ex_a = int'(mem_addr);
    ex_d = int'(din);
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < N; i++) begin
        xs[i] = $urandom_range(0, 335);
        ys[i] = $urandom_range(0, 255);
        ds[i] = $urandom_range(0, 255);
      end
      set_req($urandom_range(0, 3), xs[0], ys[0], ds[0], xs[1], ys[1], ds[1]);
      g = -1;
      for (int k = N; k >= 1; k--) if (req_valid[(last_g + k) % N]) g = (last_g + k) % N;
      ex_w = 0;
      ex_drop = 0;
      if (g >= 0) begin
        last_g = g;
        if (xs[g] < 320 && ys[g] < 240) begin
          ex_w = 1;
          ex_a = ys[g] * 320 + xs[g];
          ex_d = ds[g];
        end else ex_drop = 1;
      end
      @(negedge clk);
      chk("rnd_ready", int'(req_ready), g < 0 ? 0 : (1 << g));
      @(posedge clk); #1;
      chk("rnd_wen", int'(wen), ex_w);
      chk("rnd_addr", int'(mem_addr), ex_a);
      chk("rnd_din", int'(din), ex_d);
      chk("rnd_drop", int'(drop_err), ex_drop);
    end
    set_req(2, 0, 0, 0, 5, 6, 119);
    clear_start = 1'b1;
    clear_color = 8'h30;
    @(negedge clk);
    chk("clr_sim_ready", int'(req_ready), 0);
    @(posedge clk); #1;
    clear_start = 1'b0;
    bad = 0;
    for (int k = 0; k < DEPTH; k++) begin
      if (!(wen && int'(mem_addr) == k && din == 8'h30 && clear_busy && !clear_done && req_ready == '0))
        bad++;
      @(posedge clk); #1;
    end
    chk("clr_bad_cycles", bad, 0);
    chk("clr_done", int'(clear_done), 1);
    chk("clr_done_wen", int'(wen), 0);
    chk("clr_done_busy", int'(clear_busy), 0);
    chk("clr_after_ready", int'(req_ready), 2);
    @(posedge clk); #1;
    set_req(0, 0, 0, 0, 0, 0, 0);
    chk("clr_after_wen", int'(wen), 1);
    chk("clr_after_addr", int'(mem_addr), 6 * 320 + 5);
    chk("clr_after_din", int'(din), 119);
    chk("clr_done_pulse", int'(clear_done), 0);
    clear_start = 1'b1;
    clear_color = 8'h44;
    @(posedge clk); #1;
    clear_start = 1'b0;
    for (int n = 0; n < 2000 && mem_addr != 17'd1000; n++) begin
      @(posedge clk); #1;
    end
    chk("abort_reach", int'(mem_addr), 1000);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_wen", int'(wen), 0);
    chk("abort_busy", int'(clear_busy), 0);
    chk("abort_addr", int'(mem_addr), 0);
    chk("abort_din", int'(din), 0);
    bad = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (clear_done) bad++;
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      if (clear_done) bad++;
    end
    chk("abort_no_done", bad, 0);
    clear_start = 1'b1;
    @(posedge clk); #1;
    clear_start = 1'b0;
    chk("restart_wen", int'(wen), 1);
    chk("restart_addr", int'(mem_addr), 0);
    chk("restart_din", int'(din), 8'h44);
    chk("restart_busy", int'(clear_busy), 1);
    @(posedge clk); #1;
    chk("restart_addr1", int'(mem_addr), 1);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/fb_write_arbiter.md
# fb_write_arbiter

Write-side controller for the 320x240 8-bit VGA framebuffer. Shares the framebuffer's single write port (mem_addr/din/wen) between NUM_REQ pixel writers with round-robin arbitration, converts (x, y) coordinates to linear addresses, and provides a hardware full-screen clear sequencer that takes exclusive ownership of the port while running. Sits between drawing agents (host, sprite/line engines) and the framebuffer memory module.

## Interface

- RES_X, 320, horizontal resolution in pixels
- RES_Y, 240, vertical resolution in pixels
- MEM_WIDTH, 8, pixel word width
- MEM_DEPTH, RES_X*RES_Y, framebuffer words
- ADDR_WIDTH, $clog2(MEM_DEPTH) (17), framebuffer address width
- X_W, $clog2(RES_X) (9), x coordinate width
- Y_W, $clog2(RES_Y) (8), y coordinate width
- NUM_REQ, 2, number of requesters (>=2)

- clk  in  1  single system clock
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester write request
- req_ready  out  NUM_REQ  per-requester accept; transfer when valid && ready
- req_x  in  NUM_REQ*X_W  packed x coordinates, requester i at [i*X_W +: X_W]
- req_y  in  NUM_REQ*Y_W  packed y coordinates
- req_data  in  NUM_REQ*MEM_WIDTH  packed pixel values
- clear_start  in  1  start full-screen clear (sampled in IDLE only)
- clear_color  in  MEM_WIDTH  fill value, captured at clear start
- clear_busy  out  1  high while clear owns the port
- clear_done  out  1  one-cycle pulse at clear completion
- drop_err  out  1  one-cycle pulse: accepted request had out-of-range coordinates
- mem_addr  out  ADDR_WIDTH  framebuffer write address
- din  out  MEM_WIDTH  framebuffer write data
- wen  out  1  framebuffer write enable

## Operation

- States: IDLE, CLEAR. Reset -> IDLE.
- IDLE, clear_start=1: capture clear_color, clear counter=0, go CLEAR; no req_ready that cycle (clear wins over simultaneous requests).
- IDLE, clear_start=0: round-robin arbiter picks one valid requester; exactly that req_ready bit high (combinational from req_valid, at most one bit set). Search starts at requester after the last granted one; pointer updates only on a completed transfer.
- Accepted request: if req_x<RES_X and req_y<RES_Y, write addr = req_y*RES_X + req_x (ADDR_WIDTH arithmetic, no overflow in range), din=req_data. Otherwise request is consumed, no write, drop_err pulses.
- CLEAR: writes clear_color to addresses 0..MEM_DEPTH-1, one per cycle; req_ready all 0; clear_start ignored. After address MEM_DEPTH-1 is issued, return to IDLE.
- Reset asserted mid-clear aborts it immediately; no completion pulse.

## Timing

- All outputs registered except req_ready. Reset values: mem_addr=0, din=0, wen=0, clear_busy=0, clear_done=0, drop_err=0, req_ready=0, RR pointer=0 (requester 0 highest priority first).
- Request latency: handshake in cycle t -> wen=1 with addr/data in cycle t+1. Back-to-back accepts sustain one write per cycle.
- drop_err pulses in cycle t+1 with wen=0.
- Clear: clear_start in cycle t -> wen=1, mem_addr=0 in t+1; mem_addr=MEM_DEPTH-1 in t+MEM_DEPTH; clear_busy high t+1..t+MEM_DEPTH; clear_done pulses t+MEM_DEPTH+1 with wen=0; requests may be accepted in cycle t+MEM_DEPTH+1 (writes land t+MEM_DEPTH+2).
- wen deasserts in any cycle with no accept and no clear write; mem_addr/din hold last values.

## Structure

- Package fb_pkg: RES_X, RES_Y, MEM_DEPTH, ADDR_WIDTH, X_W, Y_W, MEM_WIDTH constants; state enum (IDLE, CLEAR); pixel_t typedef.
- Sub-module rr_arbiter (NUM_REQ parameter): req vector in, one-hot grant out, pointer advance on accept input.
- Top: FSM, clear counter, coordinate-to-address multiply-add, output registers.

## Test plan

- Reset: rst_n low mid-activity -> all outputs 0 immediately; after release, single req on requester 0 (x=10,y=10,data=0x0C) -> wen=1, mem_addr=3210, din=0x0C next cycle.
- Contention: both requesters valid continuously for 6 cycles -> grants alternate 0,1,0,1,0,1; six consecutive writes, no gaps.
- Range: x=320,y=0 and x=0,y=240 -> accepted, wen=0, drop_err pulses; x=319,y=239 -> mem_addr=76799.
- Clear: clear_start with clear_color=0x30 -> 76800 consecutive writes of 0x30, addresses 0..76799, clear_busy high throughout, clear_done one pulse after; req_ready stays 0 throughout.
- Simultaneous: clear_start and req_valid[1] same IDLE cycle -> clear wins, req_ready=0; request accepted cycle after clear_done... (t+76801), written one cycle later.
- Abort: reset at address 1000 of a clear -> wen=0, clear_busy=0, no clear_done; new clear_start afterwards restarts at address 0.
